// File: rtl/gpi_debounce.sv
// ============================================================================
// Module      : gpi_debounce
// Description : Per-bit synchronizer and counter debouncer for raw board inputs,
//               with rise/fall pulses, sticky W1C event flags and an interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpi_debounce #(
  parameter int Width          = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 50000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] gp_raw_i,
  input  logic [Width-1:0] edge_en_i,
  input  logic [Width-1:0] clr_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] event_o,
  output logic             irq_o
);

  localparam int              CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0][Width-1:0] sync_q, sync_d;
  logic [Width-1:0][CntW-1:0]       cnt_q, cnt_d;
  logic [Width-1:0]                 gp_q, gp_d;
  logic [Width-1:0]                 rise_q, rise_d;
  logic [Width-1:0]                 fall_q, fall_d;
  logic [Width-1:0]                 event_q, event_d;
  logic [Width-1:0]                 sync_last;
  logic [Width-1:0]                 flip;

  assign sync_last = sync_q[SyncStages-1];

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], gp_raw_i};
    cnt_d  = '0;
    flip   = '0;
    for (int i = 0; i < Width; i++) begin
      // Any return to the accepted level discards the partial count.
      if (sync_last[i] != gp_q[i]) begin
        if (cnt_q[i] >= CntMax) begin
          flip[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    gp_d    = gp_q ^ flip;
    rise_d  = flip & ~gp_q;
    fall_d  = flip & gp_q;
    // A new edge beats a simultaneous clear so no event is ever lost.
    event_d = (event_q & ~clr_i) | ((rise_q | fall_q) & edge_en_i);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      gp_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      gp_q    <= gp_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign gp_o    = gp_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;
  assign irq_o   = |event_q;

endmodule

`default_nettype wire

// File: tb/tb_gpi_debounce.sv
// ============================================================================
// Module      : tb_gpi_debounce
// Description : Directed scoreboard bench for gpi_debounce (4 bits, 2 sync, 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpi_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw = '0;
  logic [3:0] en = '0;
  logic [3:0] clr = '0;
  logic [3:0] gp, rise, fall, ev;
  logic       irq;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [16:0] exp;
  } exp_t;

  exp_t sb[$];

  gpi_debounce #(
    .Width         (4),
    .SyncStages    (2),
    .DebounceCycles(4)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .gp_raw_i  (raw),
    .edge_en_i (en),
    .clr_i     (clr),
    .gp_o      (gp),
    .rise_o    (rise),
    .fall_o    (fall),
    .event_o   (ev),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] obs();
    return {gp, rise, fall, ev, irq};
  endfunction

  function automatic logic [16:0] pack(input logic [3:0] g, input logic [3:0] r,
                                       input logic [3:0] f, input logic [3:0] e);
    return {g, r, f, e, (e != 4'b0000)};
  endfunction

  task automatic check_now(input string tag, input logic [16:0] exp);
    vectors++;
    assert (obs() === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed gp/rise/fall/ev/irq=%h expected %h", tag, obs(), exp);
    end
  endtask

  // Queue an expected output snapshot d edges from now, kept sorted by cycle.
  task automatic expect_at(input int d, input string tag, input logic [3:0] g,
                           input logic [3:0] r, input logic [3:0] f, input logic [3:0] e);
    exp_t x;
    int   k;
    x.cyc = cyc + d;
    x.tag = tag;
    x.exp = pack(g, r, f, e);
    k = 0;
    while (k < sb.size() && sb[k].cyc <= x.cyc) k++;
    sb.insert(k, x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc == cyc) begin
        check_now(e.tag, e.exp);
      end else begin
        vectors++;
        miscompares++;
        $error("FAIL %s: observed check at cycle %0d expected cycle %0d", e.tag, cyc, e.cyc);
      end
    end
  end

  initial begin
    // Reset state, then idle with all inputs low.
    #2;
    check_now("reset_async", 17'h0);
    tick(3);
    rst_n = 1'b1;
    for (int d = 1; d <= 20; d++) expect_at(d, "idle", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(20);

    // Bit 0 rises: gp at +6, event at +7.
    raw = 4'b0001;
    en  = 4'b0001;
    for (int d = 1; d <= 5; d++) expect_at(d, "s1_latency", 4'h0, 4'h0, 4'h0, 4'h0);
    expect_at(6, "s1_rise", 4'b0001, 4'b0001, 4'h0, 4'h0);
    expect_at(7, "s1_event", 4'b0001, 4'h0, 4'h0, 4'b0001);
    expect_at(8, "s1_hold", 4'b0001, 4'h0, 4'h0, 4'b0001);
    tick(8);

    // Bit 1 bounces 3 high / 1 low / 3 high: never accepted.
    for (int d = 1; d <= 14; d++) expect_at(d, "s2_bounce", 4'b0001, 4'h0, 4'h0, 4'b0001);
    raw = 4'b0011;
    tick(3);
    raw = 4'b0001;
    tick(1);
    raw = 4'b0011;
    tick(3);
    raw = 4'b0001;
    tick(7);

    // Bit 0 falls with clear in the pulse cycle: set wins, then clear alone.
    raw = 4'b0000;
    for (int d = 1; d <= 5; d++) expect_at(d, "s3_wait", 4'b0001, 4'h0, 4'h0, 4'b0001);
    expect_at(6, "s3_fall_clr", 4'h0, 4'h0, 4'b0001, 4'b0001);
    expect_at(7, "s3_set_wins", 4'h0, 4'h0, 4'h0, 4'b0001);
    expect_at(8, "s3_cleared", 4'h0, 4'h0, 4'h0, 4'h0);
    expect_at(9, "s3_stay_clr", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(6);
    clr = 4'b0001;
    tick(2);
    clr = 4'b0000;
    tick(1);

    // Edges disabled: bits 2 and 3 rise apart, then fall together.
    en  = 4'b0000;
    raw = 4'b0100;
    for (int d = 1; d <= 5; d++) expect_at(d, "s4_wait", 4'h0, 4'h0, 4'h0, 4'h0);
    expect_at(6, "s4_rise2", 4'b0100, 4'b0100, 4'h0, 4'h0);
    expect_at(7, "s4_hold2", 4'b0100, 4'h0, 4'h0, 4'h0);
    expect_at(8, "s4_rise3", 4'b1100, 4'b1000, 4'h0, 4'h0);
    for (int d = 9; d <= 15; d++) expect_at(d, "s4_hold", 4'b1100, 4'h0, 4'h0, 4'h0);
    expect_at(16, "s4_fall_both", 4'h0, 4'h0, 4'b1100, 4'h0);
    expect_at(17, "s4_low", 4'h0, 4'h0, 4'h0, 4'h0);
    expect_at(18, "s4_low", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(2);
    raw = 4'b1100;
    tick(8);
    raw = 4'b0000;
    tick(8);

    // Inputs high across reset release, then reset mid-count.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    raw   = 4'b1111;
    #1;
    check_now("s5_reset", 17'h0);
    tick(2);
    rst_n = 1'b1;
    en    = 4'b1111;
    for (int d = 1; d <= 5; d++) expect_at(d, "s5_wait", 4'h0, 4'h0, 4'h0, 4'h0);
    expect_at(6, "s5_rise_all", 4'b1111, 4'b1111, 4'h0, 4'h0);
    expect_at(7, "s5_event_all", 4'b1111, 4'h0, 4'h0, 4'b1111);
    expect_at(8, "s5_hold", 4'b1111, 4'h0, 4'h0, 4'b1111);
    tick(8);
    raw = 4'b0000;
    tick(3);
    @(negedge clk);
    #1;
    check_now("s5_midcount", pack(4'b1111, 4'h0, 4'h0, 4'b1111));
    rst_n = 1'b0;
    #1;
    check_now("s5_reset_mid", 17'h0);
    tick(2);

    vectors++;
    assert (sb.size() == 0)
    else begin
      miscompares++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
